// File: rtl/skel_pkg.sv
// Shared types and helpers for the Zhang-Suen thinning engine: FSM states,
// neighbour offsets (P2..P9 clockwise from north) and the deletion decision.
package skel_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_CENTER,
    ST_RD_NBR,
    ST_EVAL,
    ST_DEL,
    ST_DEL_HOLD,
    ST_CHECK,
    ST_DONE
  } state_e;

  // Row/column offsets for P2=N, P3=NE, P4=E, P5=SE, P6=S, P7=SW, P8=W, P9=NW.
  localparam int NBR_DR [8] = '{-1, -1, 0, 1, 1, 1, 0, -1};
  localparam int NBR_DC [8] = '{ 0,  1, 1, 1, 0, -1, -1, -1};

  function automatic logic [3:0] zs_count_b(input logic [7:0] nbrs);
    logic [3:0] b;
    b = 4'd0;
    for (int i = 0; i < 8; i++) b = b + {3'b000, nbrs[i]};
    return b;
  endfunction

  // 0->1 transitions walking P2..P9 and wrapping back to P2.
  function automatic logic [3:0] zs_count_a(input logic [7:0] nbrs);
    logic [3:0] a;
    a = 4'd0;
    for (int i = 0; i < 8; i++) begin
      if (!nbrs[i] && nbrs[(i + 1) % 8]) a = a + 4'd1;
    end
    return a;
  endfunction

  // nbrs[0]=P2 ... nbrs[7]=P9; subiter 0 = first sub-iteration, 1 = second.
  function automatic logic zs_deletable(input logic [7:0] nbrs, input logic subiter);
    logic [3:0] b;
    logic [3:0] a;
    logic       p2, p4, p6, p8;
    logic       sub_ok;
    b  = zs_count_b(nbrs);
    a  = zs_count_a(nbrs);
    p2 = nbrs[0];
    p4 = nbrs[2];
    p6 = nbrs[4];
    p8 = nbrs[6];
    if (!subiter) sub_ok = !(p2 && p4 && p6) && !(p4 && p6 && p8);
    else          sub_ok = !(p2 && p4 && p8) && !(p2 && p6 && p8);
    return (b >= 4'd2) && (b <= 4'd6) && (a == 4'd1) && sub_ok;
  endfunction

endpackage

// File: rtl/zs_neighbour_eval.sv
// Combinational Zhang-Suen deletion decision for one captured 3x3 neighbourhood.
module zs_neighbour_eval
  import skel_pkg::*;
(
  input  logic [7:0] nbrs,
  input  logic       subiter,
  output logic       deletable
);

  assign deletable = zs_deletable(nbrs, subiter);

endmodule

// File: rtl/skeleton_thinning_engine.sv
// Iterative Zhang-Suen thinning controller driving a dual-port image RAM:
// scan-and-flag pass, then a delete sweep with each write held two cycles.
module skeleton_thinning_engine
  import skel_pkg::*;
#(
  parameter int N          = 8,
  parameter int bitSize    = 6,
  parameter int pixelWidth = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [7:0]            iter_count,
  output logic                  ram_we,
  output logic [bitSize:0]      ram_addr,
  output logic [pixelWidth-1:0] ram_wdata,
  output logic [bitSize:0]      ram_rd_addr,
  input  logic [pixelWidth-1:0] ram_rd_data,
  output state_e                dbg_state
);

  localparam int AW   = bitSize + 1;
  localparam int NPIX = N * N;
  localparam int PIW  = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam logic [AW-1:0] LAST_PIX = AW'(NPIX - 1);

  state_e            state, state_next;
  logic [AW-1:0]     p;
  logic [AW-1:0]     p_inc;
  logic [PIW-1:0]    pi;
  logic [2:0]        nbr_idx;
  logic [7:0]        nbrs;
  logic [NPIX-1:0]   flags;
  logic              sub_iter;
  logic              changed;
  logic              deletable;
  logic              last_pix;
  logic              nbr_in_img;
  logic [AW-1:0]     nbr_addr;
  int                cr, cc, nr, nc;
  logic              unused_rd_bits;

  assign pi        = p[PIW-1:0];
  assign last_pix  = (p == LAST_PIX);
  assign p_inc     = last_pix ? '0 : p + AW'(1);
  assign ram_wdata = '0;
  assign dbg_state = state;
  // Only bit 0 carries foreground; the rest of the RAM word is ignored.
  assign unused_rd_bits = ^ram_rd_data[pixelWidth-1:1];

  always_comb begin
    cr         = int'(p) / N;
    cc         = int'(p) % N;
    nr         = cr + NBR_DR[nbr_idx];
    nc         = cc + NBR_DC[nbr_idx];
    nbr_in_img = (nr >= 0) && (nr < N) && (nc >= 0) && (nc < N);
    nbr_addr   = AW'(nr * N + nc);
  end

  zs_neighbour_eval u_eval (
    .nbrs      (nbrs),
    .subiter   (sub_iter),
    .deletable (deletable)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next  = state;
    busy        = (state != ST_IDLE) && (state != ST_DONE);
    done        = (state == ST_DONE);
    ram_we      = 1'b0;
    ram_addr    = '0;
    ram_rd_addr = '0;
    case (state)
      ST_IDLE: if (start) state_next = ST_RD_CENTER;
      ST_RD_CENTER: begin
        ram_rd_addr = p;
        if (ram_rd_data[0]) state_next = ST_RD_NBR;
        else if (last_pix)  state_next = ST_DEL;
      end
      ST_RD_NBR: begin
        ram_rd_addr = nbr_in_img ? nbr_addr : '0;
        if (nbr_idx == 3'd7) state_next = ST_EVAL;
      end
      ST_EVAL: state_next = last_pix ? ST_DEL : ST_RD_CENTER;
      ST_DEL: begin
        ram_addr = p;
        if (flags[pi]) begin
          ram_we     = 1'b1;
          state_next = ST_DEL_HOLD;
        end else if (last_pix) begin
          state_next = sub_iter ? ST_CHECK : ST_RD_CENTER;
        end
      end
      ST_DEL_HOLD: begin
        ram_we   = 1'b1;
        ram_addr = p;
        if (last_pix) state_next = sub_iter ? ST_CHECK : ST_RD_CENTER;
        else          state_next = ST_DEL;
      end
      ST_CHECK: state_next = changed ? ST_RD_CENTER : ST_DONE;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p          <= '0;
      nbr_idx    <= '0;
      nbrs       <= '0;
      flags      <= '0;
      sub_iter   <= 1'b0;
      changed    <= 1'b0;
      iter_count <= 8'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            p          <= '0;
            nbr_idx    <= '0;
            sub_iter   <= 1'b0;
            changed    <= 1'b0;
            iter_count <= 8'd0;
          end
        end
        ST_RD_CENTER: begin
          nbr_idx <= '0;
          if (!ram_rd_data[0]) p <= p_inc;
        end
        ST_RD_NBR: begin
          nbrs[nbr_idx] <= nbr_in_img && ram_rd_data[0];
          nbr_idx       <= nbr_idx + 3'd1;
        end
        ST_EVAL: begin
          // Flags are only applied in the sweep, so the scan sees the old image.
          if (deletable) flags[pi] <= 1'b1;
          p <= p_inc;
        end
        ST_DEL: begin
          if (!flags[pi]) begin
            p <= p_inc;
            if (last_pix) sub_iter <= 1'b1;
          end
        end
        ST_DEL_HOLD: begin
          flags[pi] <= 1'b0;
          changed   <= 1'b1;
          p         <= p_inc;
          if (last_pix) sub_iter <= 1'b1;
        end
        ST_CHECK: begin
          if (iter_count != 8'hFF) iter_count <= iter_count + 8'd1;
          if (changed) begin
            changed  <= 1'b0;
            sub_iter <= 1'b0;
            p        <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_skeleton_thinning_engine.sv
// Directed bench for skeleton_thinning_engine with a behavioural dual-port RAM
// that commits writes only on alternate rising edges.
module tb_skeleton_thinning_engine;
  import skel_pkg::*;

  localparam int N    = 8;
  localparam int BS   = 6;
  localparam int PW   = 8;
  localparam int AW   = BS + 1;
  localparam int NPIX = N * N;
  localparam int MEMD = 1 << AW;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          busy, done, ram_we;
  logic [7:0]    iter_count;
  logic [AW-1:0] ram_addr, ram_rd_addr;
  logic [PW-1:0] ram_wdata, ram_rd_data;
  state_e        dbg_state;

  int checks = 0;
  int errors = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  skeleton_thinning_engine #(.N(N), .bitSize(BS), .pixelWidth(PW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .busy        (busy),
    .done        (done),
    .iter_count  (iter_count),
    .ram_we      (ram_we),
    .ram_addr    (ram_addr),
    .ram_wdata   (ram_wdata),
    .ram_rd_addr (ram_rd_addr),
    .ram_rd_data (ram_rd_data),
    .dbg_state   (dbg_state)
  );

  // ---------------- RAM model ----------------
  logic [PW-1:0] mem      [MEMD];
  logic [PW-1:0] load_img [MEMD];
  logic          load_req = 1'b0;
  logic          wr_phase = 1'b0;

  assign ram_rd_data = mem[ram_rd_addr];

  always @(posedge clk) begin
    wr_phase <= ~wr_phase;
    if (load_req) begin
      for (int i = 0; i < MEMD; i++) mem[i] <= load_img[i];
    end else if (ram_we && wr_phase) begin
      mem[ram_addr] <= ram_wdata;
    end
  end

  // ---------------- bus monitor (logging only) ----------------
  int            we_total   = 0;
  int            we_outside = 0;
  int            bad_wdata  = 0;
  int            we_cnt [MEMD];
  logic [AW-1:0] wr_log  [$];
  logic [AW-1:0] nbr_log [$];
  logic          prev_we   = 1'b0;
  logic [AW-1:0] prev_addr = '0;

  initial for (int i = 0; i < MEMD; i++) we_cnt[i] = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (ram_we) begin
        we_total++;
        we_cnt[ram_addr]++;
        if (ram_wdata != '0) bad_wdata++;
        if (dbg_state != ST_DEL && dbg_state != ST_DEL_HOLD) we_outside++;
        if (!prev_we || ram_addr != prev_addr) wr_log.push_back(ram_addr);
      end
      if (dbg_state == ST_RD_NBR) nbr_log.push_back(ram_rd_addr);
      prev_we   = ram_we;
      prev_addr = ram_addr;
    end else begin
      prev_we = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic load_image(input logic [PW-1:0] bg);
    for (int i = 0; i < MEMD; i++) load_img[i] = bg;
  endtask

  task automatic commit_image();
    @(negedge clk);
    load_req = 1'b1;
    @(posedge clk);
    #1 load_req = 1'b0;
  endtask

  // Cycles counts rising edges after the start-sampling edge until done is seen.
  task automatic run_engine(input int restart_at, output int cycles, output logic busy_after);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    busy_after = busy;
    cycles = 0;
    while (done !== 1'b1 && cycles < 5000) begin
      start = (cycles == restart_at);
      @(posedge clk);
      #1 cycles++;
    end
    start = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%0b exp=0", done); end
    checks++; if (iter_count !== 8'd0) begin errors++; $display("FAIL reset_iter got=%0d exp=0", iter_count); end
    checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL reset_we got=%0b exp=0", ram_we); end
    checks++; if (ram_addr !== '0 || ram_rd_addr !== '0) begin
      errors++; $display("FAIL reset_addr got=%0d/%0d exp=0/0", ram_addr, ram_rd_addr);
    end
    checks++; if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL reset_state got=%0d exp=%0d", dbg_state, ST_IDLE); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_empty();
    int   cyc;
    logic b_after;
    int   we0;
    load_image(8'h00);
    commit_image();
    we0 = we_total;
    run_engine(-1, cyc, b_after);
    checks++; if (b_after !== 1'b1) begin errors++; $display("FAIL empty_busy_after_start got=%0b exp=1", b_after); end
    // 256 scan/sweep cycles + CHECK: done is the 258th cycle counting the sampling cycle.
    checks++; if (cyc != 257) begin errors++; $display("FAIL empty_latency got=%0d exp=257", cyc); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL empty_busy_at_done got=%0b exp=0", busy); end
    checks++; if (iter_count !== 8'd1) begin errors++; $display("FAIL empty_iter got=%0d exp=1", iter_count); end
    checks++; if (we_total - we0 != 0) begin errors++; $display("FAIL empty_writes got=%0d exp=0", we_total - we0); end
    @(posedge clk);
    #1;
    checks++; if (done !== 1'b0 || dbg_state !== ST_IDLE) begin
      errors++; $display("FAIL empty_done_pulse got=done %0b state %0d exp=done 0 state %0d", done, dbg_state, ST_IDLE);
    end
  endtask

  task automatic test_block();
    int            cyc;
    logic          b_after;
    int            wr_base;
    int            cnt_base [4];
    int            diffs;
    logic [AW-1:0] exp_wr [4];
    exp_wr = '{7'd27, 7'd28, 7'd35, 7'd36};
    load_image(8'h00);
    load_img[27] = 8'h01; load_img[28] = 8'h01;
    load_img[35] = 8'h01; load_img[36] = 8'h01;
    commit_image();
    wr_base = wr_log.size();
    for (int i = 0; i < 4; i++) cnt_base[i] = we_cnt[exp_wr[i]];
    run_engine(-1, cyc, b_after);
    // Iter 1: scan 100 + sweep 68 + scan 64 + sweep 64, CHECK; iter 2: 256, CHECK.
    checks++; if (cyc != 554) begin errors++; $display("FAIL block_latency got=%0d exp=554", cyc); end
    checks++; if (iter_count !== 8'd2) begin errors++; $display("FAIL block_iter got=%0d exp=2", iter_count); end
    checks++; if (wr_log.size() - wr_base != 4) begin
      errors++; $display("FAIL block_write_count got=%0d exp=4", wr_log.size() - wr_base);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (wr_log.size() > wr_base + i && wr_log[wr_base + i] !== exp_wr[i]) begin
        errors++; $display("FAIL block_write_order[%0d] got=%0d exp=%0d", i, wr_log[wr_base + i], exp_wr[i]);
      end else if (wr_log.size() <= wr_base + i) begin
        errors++; $display("FAIL block_write_order[%0d] got=none exp=%0d", i, exp_wr[i]);
      end
      checks++;
      if (we_cnt[exp_wr[i]] - cnt_base[i] != 2) begin
        errors++; $display("FAIL block_hold[%0d] got=%0d cycles exp=2", exp_wr[i], we_cnt[exp_wr[i]] - cnt_base[i]);
      end
    end
    diffs = 0;
    for (int i = 0; i < NPIX; i++) if (mem[i] !== 8'h00) diffs++;
    checks++; if (diffs != 0) begin errors++; $display("FAIL block_ram_clear got=%0d nonzero exp=0", diffs); end
    checks++; if (bad_wdata != 0 || we_outside != 0) begin
      errors++; $display("FAIL block_bus got=wdata %0d outside %0d exp=0 0", bad_wdata, we_outside);
    end
  endtask

  // Line on row 3, cols 1..5; background words have bit0 clear but other bits set.
  task automatic test_line();
    int   cyc;
    logic b_after;
    int   we0;
    int   diffs;
    load_image(8'hFE);
    for (int c = 1; c <= 5; c++) load_img[3 * N + c] = 8'hA5;
    commit_image();
    we0 = we_total;
    run_engine(-1, cyc, b_after);
    checks++; if (cyc != 347) begin errors++; $display("FAIL line_latency got=%0d exp=347", cyc); end
    checks++; if (iter_count !== 8'd1) begin errors++; $display("FAIL line_iter got=%0d exp=1", iter_count); end
    checks++; if (we_total - we0 != 0) begin errors++; $display("FAIL line_writes got=%0d exp=0", we_total - we0); end
    diffs = 0;
    for (int i = 0; i < NPIX; i++) if (mem[i] !== load_img[i]) diffs++;
    checks++; if (diffs != 0) begin errors++; $display("FAIL line_ram_kept got=%0d changed exp=0", diffs); end
  endtask

  task automatic test_corner();
    int            cyc;
    logic          b_after;
    int            we0;
    int            nb_base;
    int            bad;
    logic [AW-1:0] exp_nb [16];
    exp_nb = '{7'd0, 7'd0, 7'd1, 7'd9,  7'd8, 7'd0, 7'd0, 7'd0,
               7'd0, 7'd0, 7'd2, 7'd10, 7'd9, 7'd8, 7'd0, 7'd0};
    load_image(8'h00);
    load_img[0] = 8'h01;
    load_img[1] = 8'h01;
    commit_image();
    we0     = we_total;
    nb_base = nbr_log.size();
    run_engine(-1, cyc, b_after);
    checks++; if (cyc != 293) begin errors++; $display("FAIL corner_latency got=%0d exp=293", cyc); end
    checks++; if (iter_count !== 8'd1) begin errors++; $display("FAIL corner_iter got=%0d exp=1", iter_count); end
    checks++; if (we_total - we0 != 0) begin errors++; $display("FAIL corner_writes got=%0d exp=0", we_total - we0); end
    checks++; if (nbr_log.size() - nb_base != 32) begin
      errors++; $display("FAIL corner_nbr_cycles got=%0d exp=32", nbr_log.size() - nb_base);
    end
    bad = 0;
    for (int i = 0; i < 32; i++) begin
      if (nbr_log.size() > nb_base + i) begin
        if (nbr_log[nb_base + i] !== exp_nb[i % 16]) bad++;
      end else begin
        bad++;
      end
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL corner_nbr_addr got=%0d wrong exp=0", bad); end
    checks++; if (mem[0] !== 8'h01 || mem[1] !== 8'h01) begin
      errors++; $display("FAIL corner_kept got=%0h %0h exp=01 01", mem[0], mem[1]);
    end
  endtask

  task automatic test_back_to_back();
    int   cyc;
    logic b_after;
    int   we0;
    load_image(8'hFE);
    for (int c = 1; c <= 5; c++) load_img[3 * N + c] = 8'hA5;
    commit_image();
    we0 = we_total;
    run_engine(100, cyc, b_after);
    checks++; if (cyc != 347) begin errors++; $display("FAIL b2b_latency got=%0d exp=347", cyc); end
    checks++; if (iter_count !== 8'd1) begin errors++; $display("FAIL b2b_iter got=%0d exp=1", iter_count); end
    checks++; if (we_total - we0 != 0) begin errors++; $display("FAIL b2b_writes got=%0d exp=0", we_total - we0); end
    @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0 || dbg_state !== ST_IDLE) begin
      errors++; $display("FAIL b2b_idle got=busy %0b state %0d exp=busy 0 state %0d", busy, dbg_state, ST_IDLE);
    end
  endtask

  task automatic test_reset_mid();
    int            n;
    int            cyc;
    logic          b_after;
    int            we_seen;
    int            diffs;
    logic          cleared27;
    logic [PW-1:0] exp_img [NPIX];
    load_image(8'h00);
    load_img[27] = 8'h01; load_img[28] = 8'h01;
    load_img[35] = 8'h01; load_img[36] = 8'h01;
    commit_image();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    n = 0;
    while (dbg_state !== ST_DEL_HOLD && n < 2000) begin
      @(posedge clk);
      #1 n++;
    end
    checks++; if (dbg_state !== ST_DEL_HOLD) begin errors++; $display("FAIL rst_reach_hold got=%0d exp=%0d", dbg_state, ST_DEL_HOLD); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL rst_we_drop got=%0b exp=0", ram_we); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy_drop got=%0b exp=0", busy); end
    checks++; if (iter_count !== 8'd0) begin errors++; $display("FAIL rst_iter_drop got=%0d exp=0", iter_count); end
    we_seen = 0;
    repeat (3) begin
      @(posedge clk);
      #1 if (ram_we) we_seen++;
    end
    checks++; if (we_seen != 0) begin errors++; $display("FAIL rst_no_writes got=%0d exp=0", we_seen); end
    @(negedge clk);
    rst_n = 1'b1;
    // Whether the pixel-27 write landed depends on the RAM phase; both outcomes are legal.
    cleared27 = (mem[27][0] == 1'b0);
    for (int i = 0; i < NPIX; i++) exp_img[i] = 8'h00;
    if (cleared27) exp_img[36] = 8'h01;
    run_engine(-1, cyc, b_after);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL rst_restart_done got=%0b after %0d cycles exp=1", done, cyc); end
    checks++; if (iter_count !== 8'd2) begin errors++; $display("FAIL rst_restart_iter got=%0d exp=2", iter_count); end
    diffs = 0;
    for (int i = 0; i < NPIX; i++) if (mem[i] !== exp_img[i]) diffs++;
    checks++; if (diffs != 0) begin errors++; $display("FAIL rst_restart_image got=%0d differing exp=0", diffs); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    for (int i = 0; i < MEMD; i++) load_img[i] = 8'h00;
    test_reset();
    test_empty();
    test_block();
    test_line();
    test_corner();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
